regfile_mp: RTL and testbench

- Parametrised successor to the CPU's 32x32 GPR file, for the dual-issue pipeline.
- Features: configurable width and depth, two read ports, two write ports with fixed priority, same-cycle write-to-read bypass, optional registered read outputs.
- Has a post-reset clear sequencer, so no initial block or per-entry async reset is needed.
- Sits in the ID stage; the WB stage drives both write ports.

---
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file for the dual-issue ID stage: two read ports, two
// prioritised write ports, write-to-read bypass and a post-reset clear sequencer.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int REG_OUT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we1,
  output logic              busy,
  output logic              wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wen0, wen1;
  logic              conflict;
  logic [DATA_W-1:0] res0, res1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);

  // Writes to a hardwired-zero entry are dropped entirely: no store, no bypass, no conflict.
  assign wen0     = run & we0 & ~(ZR & (wa0 == '0));
  assign wen1     = run & we1 & ~(ZR & (wa1 == '0));
  assign conflict = wen0 & wen1 & (wa0 == wa1);

  // Port 1 is written last so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) begin
        mem[cnt] <= '0;
      end else begin
        if (wen0) mem[wa0] <= wd0;
        if (wen1) mem[wa1] <= wd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict;
    end
  end

  always_comb begin
    res0 = mem[ra0];
    if (!run || (ZR && (ra0 == '0))) begin
      res0 = '0;
    end else if (wen1 && (wa1 == ra0)) begin
      res0 = wd1;
    end else if (wen0 && (wa0 == ra0)) begin
      res0 = wd0;
    end
  end

  always_comb begin
    res1 = mem[ra1];
    if (!run || (ZR && (ra1 == '0))) begin
      res1 = '0;
    end else if (wen1 && (wa1 == ra1)) begin
      res1 = wd1;
    end else if (wen0 && (wa0 == ra1)) begin
      res1 = wd0;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_W-1:0] rd0_q, rd1_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd0_q <= '0;
        rd1_q <= '0;
      end else begin
        rd0_q <= res0;
        rd1_q <= res1;
      end
    end

    assign rd0 = rd0_q;
    assign rd1 = rd1_q;
  end else begin : g_comb_out
    assign rd0 = res0;
    assign rd1 = res1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one combinational-read and one registered-read
// instance share stimulus; expectations are queued with a target cycle and checked at negedge.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra0, ra1, wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        we0, we1;

  logic [31:0] c_rd0, c_rd1, r_rd0, r_rd1;
  logic        c_busy, c_conf, r_busy, r_conf;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .REG_OUT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(c_rd0), .rd1(c_rd1),
    .wa0(wa0), .wd0(wd0), .we0(we0), .wa1(wa1), .wd1(wd1), .we1(we1),
    .busy(c_busy), .wr_conflict(c_conf)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .REG_OUT(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(r_rd0), .rd1(r_rd1),
    .wa0(wa0), .wd0(wd0), .we0(we0), .wa1(wa1), .wd1(wd1), .we1(we1),
    .busy(r_busy), .wr_conflict(r_conf)
  );

  localparam int S_CRD0 = 0, S_CRD1 = 1, S_CBUSY = 2, S_CCONF = 3;
  localparam int S_RRD0 = 4, S_RRD1 = 5, S_RBUSY = 6, S_RCONF = 7;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_CRD0:  return c_rd0;
      S_CRD1:  return c_rd1;
      S_CBUSY: return {31'd0, c_busy};
      S_CCONF: return {31'd0, c_conf};
      S_RRD0:  return r_rd0;
      S_RRD1:  return r_rd1;
      S_RBUSY: return {31'd0, r_busy};
      default: return {31'd0, r_conf};
    endcase
  endfunction

  task automatic push(input int sig, input logic [31:0] exp, input int dly, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        act = actual(sb[i].sig);
        if (act !== sb[i].exp) begin
          fails++;
          $display("FAIL %s (cycle %0d, signal %0d): got %h, expected %h",
                   sb[i].name, cyc, sb[i].sig, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0;   wa1 = '0;
    wd0 = '0;   wd1 = '0;
  endtask

  task automatic sweep_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      push(S_CRD0, 32'h0, 0, name);
      push(S_CRD1, 32'h0, 0, name);
      push(S_RRD0, 32'h0, 1, name);
      push(S_RRD1, 32'h0, 1, name);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ra0 = '0; ra1 = '0;
    idle();

    // Reset and full clear with a write attempt during busy
    tick(); tick();
    push(S_CCONF, 32'h0, 0, "reset_conf");
    push(S_RCONF, 32'h0, 0, "reset_conf");
    push(S_RRD1,  32'h0, 0, "reset_rd1");
    rst_n = 1'b1;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA5555; ra0 = 5'd3;
    for (int k = 0; k < 32; k++) begin
      push(S_CBUSY, 32'h1, 0, "busy_clear");
      push(S_RBUSY, 32'h1, 0, "busy_clear");
      push(S_CRD0,  32'h0, 0, "rd_busy");
      push(S_RRD0,  32'h0, 0, "rd_busy");
      if (k == 16) push(S_CCONF, 32'h0, 0, "conf_busy");
      if (k == 31) we0 = 1'b0;
      tick();
    end
    checks++;
    if (c_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_done_direct: c_busy=%b, expected 0", c_busy);
    end
    checks++;
    if (r_busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_done_direct: r_busy=%b, expected 0", r_busy);
    end
    push(S_CBUSY, 32'h0, 0, "busy_done");
    push(S_RBUSY, 32'h0, 0, "busy_done");
    push(S_CCONF, 32'h0, 0, "conf_done");
    sweep_zero("sweep_after_clear");

    // Single write, bypass then stored
    ra0 = 5'd5; we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678;
    push(S_CRD0, 32'h12345678, 0, "bypass_wr0");
    push(S_RRD0, 32'h12345678, 1, "reg_bypass_wr0");
    tick();
    checks++;
    if (c_rd0 !== 32'h12345678) begin
      fails++;
      $display("FAIL stored_wr0_direct: got %h, expected 12345678", c_rd0);
    end
    we0 = 1'b0;
    push(S_CRD0, 32'h12345678, 0, "stored_wr0");
    push(S_RRD0, 32'h12345678, 1, "reg_stored_wr0");
    tick();

    // Same-address dual write: port 1 wins, one-cycle conflict pulse
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
    wd0 = 32'h11111111; wd1 = 32'h22222222; ra0 = 5'd7; ra1 = 5'd7;
    push(S_CRD1,  32'h22222222, 0, "bypass_prio_rd1");
    push(S_CRD0,  32'h22222222, 0, "bypass_prio_rd0");
    push(S_CCONF, 32'h0, 0, "conf_before");
    push(S_CCONF, 32'h1, 1, "conf_pulse");
    push(S_RCONF, 32'h1, 1, "conf_pulse");
    push(S_RRD1,  32'h22222222, 1, "reg_bypass_prio");
    tick();
    checks++;
    if (c_conf !== 1'b1) begin
      fails++;
      $display("FAIL conf_pulse_direct: c_conf=%b, expected 1", c_conf);
    end
    idle();
    push(S_CRD0,  32'h22222222, 0, "stored_conflict");
    push(S_CCONF, 32'h0, 1, "conf_one_cycle");
    push(S_RCONF, 32'h0, 1, "conf_one_cycle");
    tick();

    // Independent dual write
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'hA0A0A0A0;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hB0B0B0B0;
    ra0 = 5'd8; ra1 = 5'd9;
    push(S_CRD0, 32'hA0A0A0A0, 0, "bypass_indep0");
    push(S_CRD1, 32'hB0B0B0B0, 0, "bypass_indep1");
    tick();
    idle();
    push(S_CRD0,  32'hA0A0A0A0, 0, "stored_indep0");
    push(S_CRD1,  32'hB0B0B0B0, 0, "stored_indep1");
    push(S_CCONF, 32'h0, 0, "conf_indep");
    push(S_RCONF, 32'h0, 0, "conf_indep");
    push(S_RRD0,  32'hA0A0A0A0, 1, "reg_stored_indep0");
    push(S_RRD1,  32'hB0B0B0B0, 1, "reg_stored_indep1");
    tick();

    // Both ports write entry 0: dropped, no bypass, no conflict
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h12121212;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
    ra0 = 5'd0; ra1 = 5'd0;
    push(S_CRD0,  32'h0, 0, "zero_no_bypass0");
    push(S_CRD1,  32'h0, 0, "zero_no_bypass1");
    push(S_CCONF, 32'h0, 1, "zero_no_conflict");
    push(S_RCONF, 32'h0, 1, "zero_no_conflict");
    push(S_RRD0,  32'h0, 1, "reg_zero");
    tick();
    idle();
    ra1 = 5'd7;
    push(S_CRD0, 32'h0, 0, "zero_stored");
    push(S_CRD1, 32'h22222222, 0, "entry7_kept");
    tick();

    // Registered read latency, then reset clears the output registers
    ra0 = 5'd12; we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hCAFEF00D;
    push(S_RRD0, 32'h0, 0, "regout_not_before");
    push(S_CRD0, 32'hCAFEF00D, 0, "bypass_wr12");
    push(S_RRD0, 32'hCAFEF00D, 1, "regout_latency");
    tick();
    we0 = 1'b0;
    rst_n = 1'b0;
    push(S_CRD0,  32'hCAFEF00D, 0, "stored_pre_reset");
    push(S_RRD0,  32'h0, 1, "regout_reset");
    push(S_CBUSY, 32'h1, 1, "busy_on_reset");
    push(S_RBUSY, 32'h1, 1, "busy_on_reset");
    tick();

    // Reset again at cnt=10: a fresh full clear follows
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(S_CBUSY, 32'h1, 0, "busy_partial");
      tick();
    end
    rst_n = 1'b0;
    push(S_CBUSY, 32'h1, 0, "busy_mid_reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      push(S_CBUSY, 32'h1, 0, "busy_restart");
      push(S_RBUSY, 32'h1, 0, "busy_restart");
      tick();
    end
    push(S_CBUSY, 32'h0, 0, "busy_restart_done");
    push(S_RBUSY, 32'h0, 0, "busy_restart_done");
    sweep_zero("sweep_after_restart");

    idle();
    repeat (3) @(negedge clk);
    #1;
    foreach (sb[i]) begin
      checks++;
      fails++;
      $display("FAIL %s: expectation for cycle %0d never checked", sb[i].name, sb[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
